// File: rtl/vout_timing_gen_quad_pkg.sv
// rtl/vout_timing_gen_quad_pkg.sv - shared FSM encoding and reference 1080p60 timing
package vout_timing_gen_quad_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int H1080_FP     = 88;
    localparam int H1080_SYNC   = 44;
    localparam int H1080_BP     = 148;
    localparam int H1080_ACTIVE = 1920;
    localparam int H1080_TOTAL  = 2200;

    localparam int V1080_FP     = 4;
    localparam int V1080_SYNC   = 5;
    localparam int V1080_BP     = 36;
    localparam int V1080_ACTIVE = 1080;
    localparam int V1080_TOTAL  = 1125;

endpackage

// File: rtl/vout_axis_decode.sv
// rtl/vout_axis_decode.sv - per-axis region decode: sync, active and active-area coordinate
module vout_axis_decode #(
    parameter int CW = 12
) (
    input  logic [CW-1:0] cnt,
    input  logic [CW-1:0] sync,
    input  logic [CW-1:0] bp,
    input  logic [CW-1:0] active,
    output logic          in_sync,
    output logic          in_active,
    output logic [CW-1:0] coord
);

    logic [CW:0] act_start;
    logic [CW:0] act_end;

    // One extra bit keeps sync+bp+active from wrapping back into the line
    always_comb begin
        act_start = {1'b0, sync} + {1'b0, bp};
        act_end   = act_start + {1'b0, active};
        in_sync   = cnt < sync;
        in_active = ({1'b0, cnt} >= act_start) && ({1'b0, cnt} < act_end);
        coord     = in_active ? (cnt - act_start[CW-1:0]) : '0;
    end

endmodule

// File: rtl/vout_timing_gen_quad.sv
// rtl/vout_timing_gen_quad.sv - video timing generator with shadowed config and quadrant tagging
module vout_timing_gen_quad
    import vout_timing_gen_quad_pkg::*;
#(
    parameter int CW       = 12,
    parameter int RST_HTOT = 0,
    parameter int RST_VTOT = 0
) (
    input  logic          dp_clk,
    input  logic          rst,
    input  logic [CW-1:0] h_fp,
    input  logic [CW-1:0] h_sync,
    input  logic [CW-1:0] h_bp,
    input  logic [CW-1:0] h_active,
    input  logic [CW-1:0] h_total,
    input  logic [CW-1:0] v_fp,
    input  logic [CW-1:0] v_sync,
    input  logic [CW-1:0] v_bp,
    input  logic [CW-1:0] v_active,
    input  logic [CW-1:0] v_total,
    input  logic          hs_pol,
    input  logic          vs_pol,
    input  logic          cfg_update,
    output logic          hs,
    output logic          vs,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic [1:0]    quad_id,
    output logic          sof,
    output logic          eol
);

    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic [CW-1:0] TWO = CW'(2);

    state_t        state;
    logic          pending;
    logic [CW-1:0] h_cnt, v_cnt;
    logic [CW-1:0] sh_hfp, sh_hsync, sh_hbp, sh_hact, sh_htot;
    logic [CW-1:0] sh_vfp, sh_vsync, sh_vbp, sh_vact, sh_vtot;
    logic          sh_hpol, sh_vpol;

    logic          h_in_sync, h_in_act, v_in_sync, v_in_act;
    logic [CW-1:0] h_coord, v_coord;
    logic          h_wrap, v_wrap, frame_end, shadow_ok, new_ok, do_load, de_c;

    vout_axis_decode #(.CW(CW)) u_h_decode (
        .cnt(h_cnt), .sync(sh_hsync), .bp(sh_hbp), .active(sh_hact),
        .in_sync(h_in_sync), .in_active(h_in_act), .coord(h_coord)
    );

    vout_axis_decode #(.CW(CW)) u_v_decode (
        .cnt(v_cnt), .sync(sh_vsync), .bp(sh_vbp), .active(sh_vact),
        .in_sync(v_in_sync), .in_active(v_in_act), .coord(v_coord)
    );

    always_comb begin
        h_wrap    = h_cnt == sh_htot - ONE;
        v_wrap    = v_cnt == sh_vtot - ONE;
        frame_end = h_wrap && v_wrap;
        shadow_ok = (sh_htot >= TWO) && (sh_vtot >= TWO);
        new_ok    = (h_total >= TWO) && (v_total >= TWO);
        do_load   = (state == ST_IDLE) ? pending : (frame_end && (pending || cfg_update));
        de_c      = h_in_act && v_in_act;
    end

    always_ff @(posedge dp_clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            pending  <= 1'b0;
            h_cnt    <= '0;
            v_cnt    <= '0;
            sh_hfp   <= '0;
            sh_hsync <= '0;
            sh_hbp   <= '0;
            sh_hact  <= '0;
            sh_htot  <= CW'(RST_HTOT);
            sh_vfp   <= '0;
            sh_vsync <= '0;
            sh_vbp   <= '0;
            sh_vact  <= '0;
            sh_vtot  <= CW'(RST_VTOT);
            sh_hpol  <= 1'b1;
            sh_vpol  <= 1'b1;
            hs       <= 1'b0;
            vs       <= 1'b0;
            de       <= 1'b0;
            x        <= '0;
            y        <= '0;
            quad_id  <= 2'b00;
            sof      <= 1'b0;
            eol      <= 1'b0;
        end else begin
            if (do_load) begin
                pending  <= 1'b0;
                sh_hfp   <= h_fp;
                sh_hsync <= h_sync;
                sh_hbp   <= h_bp;
                sh_hact  <= h_active;
                sh_htot  <= h_total;
                sh_vfp   <= v_fp;
                sh_vsync <= v_sync;
                sh_vbp   <= v_bp;
                sh_vact  <= v_active;
                sh_vtot  <= v_total;
                sh_hpol  <= hs_pol;
                sh_vpol  <= vs_pol;
            end else if (cfg_update) begin
                pending <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    h_cnt   <= '0;
                    v_cnt   <= '0;
                    hs      <= ~sh_hpol;
                    vs      <= ~sh_vpol;
                    de      <= 1'b0;
                    x       <= '0;
                    y       <= '0;
                    quad_id <= 2'b00;
                    sof     <= 1'b0;
                    eol     <= 1'b0;
                    if (shadow_ok)
                        state <= ST_RUN;
                end
                ST_RUN: begin
                    h_cnt <= h_wrap ? '0 : h_cnt + ONE;
                    if (h_wrap)
                        v_cnt <= v_wrap ? '0 : v_cnt + ONE;
                    if (!shadow_ok || (do_load && !new_ok))
                        state <= ST_IDLE;
                    // Outputs use the shadow as it stands this cycle, so a frame-end load lands with counter 0
                    hs      <= sh_hpol ? h_in_sync : ~h_in_sync;
                    vs      <= sh_vpol ? v_in_sync : ~v_in_sync;
                    de      <= de_c;
                    x       <= de_c ? h_coord : '0;
                    y       <= de_c ? v_coord : '0;
                    quad_id <= {de_c && (v_coord >= (sh_vact >> 1)), de_c && (h_coord >= (sh_hact >> 1))};
                    sof     <= de_c && (h_coord == '0) && (v_coord == '0);
                    eol     <= de_c && ((h_coord == sh_hact - ONE) || h_wrap);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vout_timing_gen_quad.sv
// tb/tb_vout_timing_gen_quad.sv - scoreboard bench for vout_timing_gen_quad
module tb_vout_timing_gen_quad;

    localparam int CW = 12;

    logic          dp_clk = 1'b0;
    logic          rst = 1'b0;
    logic [CW-1:0] h_fp, h_sync, h_bp, h_active, h_total;
    logic [CW-1:0] v_fp, v_sync, v_bp, v_active, v_total;
    logic          hs_pol, vs_pol, cfg_update;
    logic          hs, vs, de, sof, eol;
    logic [CW-1:0] x, y;
    logic [1:0]    quad_id;
    logic [2*CW+6:0] outs;

    assign outs = {hs, vs, de, sof, eol, quad_id, x, y};

    vout_timing_gen_quad #(.CW(CW), .RST_HTOT(0), .RST_VTOT(0)) dut (
        .dp_clk(dp_clk), .rst(rst),
        .h_fp(h_fp), .h_sync(h_sync), .h_bp(h_bp), .h_active(h_active), .h_total(h_total),
        .v_fp(v_fp), .v_sync(v_sync), .v_bp(v_bp), .v_active(v_active), .v_total(v_total),
        .hs_pol(hs_pol), .vs_pol(vs_pol), .cfg_update(cfg_update),
        .hs(hs), .vs(vs), .de(de), .x(x), .y(y), .quad_id(quad_id), .sof(sof), .eol(eol)
    );

    always #5 dp_clk = ~dp_clk;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [1:0]    q;
        logic          sof;
        logic          eol;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic sb_on = 1'b0;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: every de pixel while the scoreboard is armed must match the head of the queue
    always @(negedge dp_clk) begin
        if (sb_on && de) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow actual x=%0d y=%0d required=no_pixel", x, y);
            end else begin
                mon_e = sb_q.pop_front();
                if (x !== mon_e.x || y !== mon_e.y || quad_id !== mon_e.q ||
                    sof !== mon_e.sof || eol !== mon_e.eol) begin
                    errors++;
                    $display("FAIL sb_pixel actual x=%0d y=%0d q=%0d sof=%0d eol=%0d required x=%0d y=%0d q=%0d sof=%0d eol=%0d",
                             x, y, quad_id, sof, eol, mon_e.x, mon_e.y, mon_e.q, mon_e.sof, mon_e.eol);
                end
            end
        end
    end

    task automatic push_frame();
        exp_t e;
        for (int yy = 0; yy < 4; yy++) begin
            for (int xx = 0; xx < 8; xx++) begin
                e.x   = CW'(xx);
                e.y   = CW'(yy);
                e.q   = {yy >= 2, xx >= 4};
                e.sof = (xx == 0) && (yy == 0);
                e.eol = (xx == 7);
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic set_cfg(input int htot, input int hfp, input logic hpol);
        h_sync = 2; h_bp = 3; h_active = 8; h_fp = CW'(hfp); h_total = CW'(htot);
        v_sync = 1; v_bp = 1; v_active = 4; v_fp = 1; v_total = 7;
        hs_pol = hpol; vs_pol = 1'b1;
    endtask

    task automatic pulse_update();
        @(negedge dp_clk);
        cfg_update = 1'b1;
        @(negedge dp_clk);
        cfg_update = 1'b0;
    endtask

    task automatic first_de_latency(output int n);
        @(negedge dp_clk);
        cfg_update = 1'b1;
        @(posedge dp_clk);
        #1 cfg_update = 1'b0;
        n = 0;
        do begin
            @(posedge dp_clk);
            #1;
            n++;
        end while (!de && n < 300);
    endtask

    task automatic wait_vs_rise(input string name);
        logic pv;
        bit ok;
        ok = 1'b0;
        pv = vs;
        for (int k = 0; k < 1000; k++) begin
            @(posedge dp_clk);
            #1;
            if (vs && !pv) begin
                ok = 1'b1;
                break;
            end
            pv = vs;
        end
        check(name, int'(ok), 1);
    endtask

    // Must be entered on a vs-rise cycle; counts one full frame up to the next vs rise
    task automatic check_frame(input string tag, input int eper, input int ehs, input int evs);
        int per, hsn, vsn, den, eoln, sofn;
        logic pv;
        per = 0; hsn = 0; vsn = 0; den = 0; eoln = 0; sofn = 0;
        for (int k = 0; k < 2000; k++) begin
            hsn += int'(hs); vsn += int'(vs); den += int'(de);
            eoln += int'(eol); sofn += int'(sof);
            per++;
            pv = vs;
            @(posedge dp_clk);
            #1;
            if (vs && !pv) break;
        end
        check({tag, "_period"}, per, eper);
        check({tag, "_hs_cycles"}, hsn, ehs);
        check({tag, "_vs_cycles"}, vsn, evs);
        check({tag, "_de_cycles"}, den, 32);
        check({tag, "_eol_count"}, eoln, 4);
        check({tag, "_sof_count"}, sofn, 1);
    endtask

    task automatic idle_check(input string name, input int ncyc);
        int bad;
        bad = 0;
        repeat (ncyc) begin
            @(negedge dp_clk);
            if (outs != '0) bad++;
        end
        check(name, bad, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int lat;
        cfg_update = 1'b0;
        set_cfg(14, 1, 1'b1);
        #2 rst = 1'b1;
        repeat (3) @(negedge dp_clk);
        check("reset_outputs", int'(outs), 0);
        rst = 1'b0;
        idle_check("idle_after_reset", 20);

        push_frame();
        sb_on = 1'b1;
        first_de_latency(lat);
        check("first_de_latency", lat, 36);
        wait_vs_rise("frame2_start");
        sb_on = 1'b0;
        check("sb_drained_1", sb_q.size(), 0);
        check_frame("frame2", 98, 14, 14);

        set_cfg(16, 3, 1'b1);
        fork
            check_frame("midupd_cur", 98, 14, 14);
            begin
                repeat (30) @(negedge dp_clk);
                pulse_update();
            end
        join
        check_frame("htot16", 112, 14, 16);

        set_cfg(16, 3, 1'b0);
        fork
            check_frame("pol_cur", 112, 14, 16);
            begin
                repeat (30) @(negedge dp_clk);
                pulse_update();
            end
        join
        check_frame("pol_neg", 112, 98, 16);

        set_cfg(1, 3, 1'b1);
        repeat (30) @(negedge dp_clk);
        pulse_update();
        repeat (150) @(negedge dp_clk);
        idle_check("idle_htot1", 40);

        set_cfg(14, 1, 1'b1);
        push_frame();
        sb_on = 1'b1;
        first_de_latency(lat);
        check("resume_de_latency", lat, 36);
        wait_vs_rise("resume_frame2_start");
        sb_on = 1'b0;
        check("sb_drained_2", sb_q.size(), 0);
        check_frame("resume_frame2", 98, 14, 14);

        // Now one cycle past the vs rise: counter at h=1, v=0; step to h=6, v=3
        repeat (47) @(posedge dp_clk);
        #1;
        check("pre_rst_de", int'(de), 1);
        check("pre_rst_y", int'(y), 1);
        rst = 1'b1;
        #1;
        check("rst_midframe_outputs", int'(outs), 0);
        repeat (3) @(negedge dp_clk);
        rst = 1'b0;
        idle_check("idle_after_rst2", 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
